// File: rtl/silent_pkg.sv
// silent_pkg: shared sizes, pipeline latencies and FSM state type for the silent sequencer.
package silent_pkg;
  localparam int WIDTH = 13;
  localparam int DEPTH = 249;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int RD_LAT = 2;
  localparam int ENG_LAT = 1;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_e;
endpackage

// File: rtl/silent_sequencer_if.sv
// silent_sequencer_if: control and RAM-sweep signal bundle of the silent sequencer.
interface silent_sequencer_if #(parameter int WIDTH = 13, parameter int ADDR_W = 8);
  logic start;
  logic enable;
  logic [WIDTH-1:0] step_in;
  logic clr_overrun;
  logic [WIDTH-1:0] step_out;
  logic rd_en;
  logic [ADDR_W-1:0] addr;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic busy;
  logic done;
  logic overrun;
  logic [15:0] ovr_cnt;
  modport master (
    output start, enable, step_in, clr_overrun,
    input step_out, rd_en, addr, wr_en, wr_addr, busy, done, overrun, ovr_cnt
  );
  modport slave (
    input start, enable, step_in, clr_overrun,
    output step_out, rd_en, addr, wr_en, wr_addr, busy, done, overrun, ovr_cnt
  );
endinterface

// File: rtl/silent_seq_delay.sv
// silent_seq_delay: fixed-latency {strobe, address} delay line aligning write-back with RAM read and step engine.
module silent_seq_delay #(
  parameter int LAT = 3,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         strobe,
  input  logic [W-1:0] addr,
  output logic         dly_strobe,
  output logic [W-1:0] dly_addr
);
  logic [W:0] sr [LAT];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < LAT; i++) sr[i] <= '0;
    else begin
      sr[0] <= {strobe, addr};
      for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
    end
  assign {dly_strobe, dly_addr} = sr[LAT-1];
endmodule

// File: rtl/silent_sequencer.sv
// silent_sequencer: per-period sweep of DEPTH channels with delayed write-back and overrun tracking.
// Define SILENT_OVR_CNT_EN to build the saturating overrun counter behind OVR_CNT.
module silent_sequencer #(
  parameter int WIDTH = silent_pkg::WIDTH,
  parameter int DEPTH = silent_pkg::DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              ENABLE,
  input  logic [WIDTH-1:0]  STEP_IN,
  input  logic              CLR_OVERRUN,
  output logic [WIDTH-1:0]  STEP_OUT,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] ADDR,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVERRUN,
  output logic [15:0]       OVR_CNT
);
  import silent_pkg::*;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_e state;
  logic start_q;
  logic start_edge;
  logic ovr_evt;
  assign start_edge = START & ~start_q;
  assign BUSY = state != IDLE;
  assign ovr_evt = start_edge & BUSY;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      start_q <= 1'b0;
      state <= IDLE;
      RD_EN <= 1'b0;
      ADDR <= '0;
      STEP_OUT <= '0;
      DONE <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      start_q <= START;
      DONE <= 1'b0;
      if (ovr_evt) OVERRUN <= 1'b1;
      else if (CLR_OVERRUN) OVERRUN <= 1'b0;
      case (state)
        IDLE:
          if (start_edge && ENABLE) begin
            state <= SWEEP;
            RD_EN <= 1'b1;
            ADDR <= '0;
            STEP_OUT <= STEP_IN;
          end
        SWEEP:
          if (ADDR == LAST) begin
            state <= DRAIN;
            RD_EN <= 1'b0;
            ADDR <= '0;
          end else ADDR <= ADDR + 1'b1;
        DRAIN:
          if (WR_EN && WR_ADDR == LAST) begin
            state <= IDLE;
            DONE <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  silent_seq_delay #(.LAT(RD_LAT + ENG_LAT), .W(ADDR_W)) u_dly (
    .clk(CLK),
    .rst_n(RESET_N),
    .strobe(RD_EN),
    .addr(ADDR),
    .dly_strobe(WR_EN),
    .dly_addr(WR_ADDR)
  );
`ifdef SILENT_OVR_CNT_EN
  logic [15:0] ovr_cnt;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) ovr_cnt <= '0;
    else if (ovr_evt) ovr_cnt <= ovr_cnt + {15'd0, ovr_cnt != 16'hFFFF};
    else if (CLR_OVERRUN) ovr_cnt <= '0;
  assign OVR_CNT = ovr_cnt;
`else
  assign OVR_CNT = '0;
`endif
endmodule

// File: doc/silent_sequencer.md
SILENT_SEQUENCER -- requirements
Module: silent_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 13: bit width of duty, phase and step values.
REQ-002 SHALL have parameter DEPTH, default 249: number of transducer channels swept per update.
REQ-003 SHALL derive localparam ADDR_W = $clog2(DEPTH), which is 8 at the default.
REQ-004 SHALL have port CLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port RESET_N, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port START, input, 1 bit: ultrasound-period strobe; it may stay high for one or more cycles.
REQ-007 SHALL have port ENABLE, input, 1 bit: permits a new sweep to begin.
REQ-008 SHALL have port STEP_IN, input, WIDTH bits: requested filter step.
REQ-009 SHALL have port CLR_OVERRUN, input, 1 bit: clears OVERRUN.
REQ-010 SHALL have port STEP_OUT, output, WIDTH bits: step value latched for the current sweep.
REQ-011 SHALL have port RD_EN, output, 1 bit: read strobe to the target and state RAMs.
REQ-012 SHALL have port ADDR, output, ADDR_W bits: read address.
REQ-013 SHALL have port WR_EN, output, 1 bit: write-back strobe for the filtered state.
REQ-014 SHALL have port WR_ADDR, output, ADDR_W bits: write-back address.
REQ-015 SHALL have ports BUSY, DONE and OVERRUN, outputs, 1 bit each: sweep in progress, one-cycle completion pulse, and sticky overrun flag.
REQ-016 SHALL have port OVR_CNT, output, 16 bits: overrun count.

Function
REQ-017 SHALL detect a START rising edge at cycle 0 when START is sampled 1 and its registered previous value is 0; START held high SHALL count as one edge only.
REQ-018 SHALL implement a state machine with states IDLE, SWEEP and DRAIN.
REQ-019 IDLE SHALL move to SWEEP on a START edge when ENABLE=1, latching STEP_IN into STEP_OUT at that edge; a START edge with ENABLE=0 SHALL be ignored.
REQ-020 SWEEP SHALL assert RD_EN in cycles 1..DEPTH, with ADDR=0 in cycle 1 and ADDR incrementing by 1 each cycle up to DEPTH-1, then SHALL move to DRAIN.
REQ-021 WR_EN and WR_ADDR SHALL equal RD_EN and ADDR delayed by exactly 3 cycles (2 cycles of RAM read latency plus 1 cycle of step engine), so write-back occurs in cycles 4..DEPTH+3.
REQ-022 DRAIN SHALL last until the last WR_EN has been issued; DONE SHALL then pulse for one cycle at cycle DEPTH+4, and the state SHALL return to IDLE in the same cycle.
REQ-023 BUSY SHALL be 1 in cycles 1..DEPTH+3 and 0 otherwise.
REQ-024 A START edge while BUSY=1 SHALL NOT restart or extend the sweep; it SHALL set OVERRUN.
REQ-025 OVERRUN SHALL stay set until CLR_OVERRUN=1; if a clear and a new overrun occur in the same cycle, the set SHALL win.
REQ-026 Deasserting ENABLE mid-sweep SHALL NOT abort the sweep; the full sweep SHALL complete.
REQ-027 STEP_OUT SHALL stay constant for the whole sweep; a change on STEP_IN mid-sweep SHALL take effect only at the next sweep.
REQ-028 STEP_IN=0 SHALL still produce a full sweep.
REQ-029 ADDR and WR_ADDR SHALL hold 0 whenever their strobe is 0, and SHALL never exceed DEPTH-1.

Reset
REQ-030 While RESET_N=0, all outputs SHALL be 0, the state SHALL be IDLE, the 3-stage delay line SHALL be flushed, and the START edge register SHALL be 0.
REQ-031 Reset asserted mid-sweep SHALL abandon the sweep with no further WR_EN and no DONE pulse.
REQ-032 START held high when reset is released SHALL count as an edge in the first cycle after release.

Configuration
REQ-033 With SILENT_OVR_CNT_EN defined, OVR_CNT SHALL increment on every overrun event, saturate at 16'hFFFF, and clear together with CLR_OVERRUN.
REQ-034 With SILENT_OVR_CNT_EN undefined, OVR_CNT SHALL be tied to 0 and no counter logic SHALL be built; the OVERRUN flag is unaffected.

Structure
REQ-035 Package silent_pkg SHALL hold WIDTH, DEPTH, ADDR_W, RD_LAT=2, ENG_LAT=1 and the state enum typedef.
REQ-036 The {strobe, address} delay line of length RD_LAT+ENG_LAT SHALL be a sub-module named silent_seq_delay.

Verification
REQ-037 START edge with ENABLE=1 and STEP_IN=100 -> RD_EN high in cycles 1..249 with ADDR 0..248, WR_EN in cycles 4..252, DONE in cycle 253, STEP_OUT=100.
REQ-038 START held high for 2 cycles -> exactly one sweep and OVERRUN=0.
REQ-039 Second START edge at cycle 100 -> sweep unchanged, OVERRUN=1, OVR_CNT=1 when SILENT_OVR_CNT_EN is defined (0 otherwise); CLR_OVERRUN=1 -> both return to 0.
REQ-040 STEP_IN changed from 100 to 50 in cycle 10 -> STEP_OUT stays 100 until the next sweep, where it is 50.
REQ-041 RESET_N pulled low in cycle 120 -> all outputs 0 immediately, no DONE; after release, a START edge runs a clean full sweep.
REQ-042 ENABLE=0 at a START edge -> no RD_EN and BUSY stays 0; ENABLE dropped in cycle 50 -> the sweep still completes with DONE in cycle 253.
